// File: rtl/smul_acc_pkg.sv
// Shared types, precision codes and lane helpers for the smul result accumulator.
package smul_acc_pkg;

  localparam int unsigned DataW    = 64;
  localparam int unsigned NumBytes = DataW / 8;

  localparam int unsigned LanesInt8  = 8;
  localparam int unsigned LanesInt16 = 4;
  localparam int unsigned LanesInt32 = 2;
  localparam int unsigned LanesInt64 = 1;

  // Precision codes as driven by the smul controller.
  localparam logic [3:0] PrecInt8  = 4'd0;
  localparam logic [3:0] PrecInt16 = 4'd1;
  localparam logic [3:0] PrecInt32 = 4'd2;
  localparam logic [3:0] PrecInt64 = 4'd3;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} smul_acc_state_t;

  typedef enum logic [1:0] {L8, L16, L32, L64} lane_mode_t;

  // Unknown codes fall back to a single full-width lane.
  function automatic lane_mode_t prec_to_mode(input logic [3:0] prec);
    case (prec)
      PrecInt8:  return L8;
      PrecInt16: return L16;
      PrecInt32: return L32;
      default:   return L64;
    endcase
  endfunction

  // Byte position mask within a lane: all-ones marks the lane's top byte.
  function automatic logic [2:0] lane_mask(input lane_mode_t mode);
    case (mode)
      L8:      return 3'(NumBytes / LanesInt8 - 1);
      L16:     return 3'(NumBytes / LanesInt16 - 1);
      L32:     return 3'(NumBytes / LanesInt32 - 1);
      default: return 3'(NumBytes / LanesInt64 - 1);
    endcase
  endfunction

  // log2 of bytes per lane; byte index >> shift gives the lane index.
  function automatic logic [1:0] lane_shift(input lane_mode_t mode);
    case (mode)
      L8:      return 2'd0;
      L16:     return 2'd1;
      L32:     return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/smul_acc_lane_add.sv
// Combinational 64-bit segmented adder; carries are killed at lane boundaries.
// Clamping to the lane's signed range is built only with SMUL_ACC_SAT_EN.
module smul_acc_lane_add
  import smul_acc_pkg::*;
(
  input  logic [DataW-1:0] a,
  input  logic [DataW-1:0] b,
  input  lane_mode_t       mode,
  output logic [DataW-1:0] sum,
  output logic [7:0]       ovf
);

  logic [2:0]       mask;
  logic [1:0]       shift;
  logic [DataW-1:0] raw;
  logic [8:0]       byte_sum;
  logic             carry;
  logic [2:0]       pos;
  logic [2:0]       lane_idx;

  assign mask  = lane_mask(mode);
  assign shift = lane_shift(mode);

  always_comb begin
    raw      = '0;
    ovf      = '0;
    carry    = 1'b0;
    byte_sum = '0;
    pos      = '0;
    lane_idx = '0;
    for (int j = 0; j < NumBytes; j++) begin
      pos      = 3'(j) & mask;
      lane_idx = 3'(j) >> shift;
      byte_sum = {1'b0, a[8*j +: 8]} + {1'b0, b[8*j +: 8]} + {8'd0, (pos != 3'd0) & carry};
      raw[8*j +: 8] = byte_sum[7:0];
      carry = byte_sum[8];
      // Signed overflow: operands agree in sign, result disagrees.
      if (pos == mask) begin
        ovf[lane_idx] = (a[8*j+7] == b[8*j+7]) && (byte_sum[7] != a[8*j+7]);
      end
    end
  end

`ifdef SMUL_ACC_SAT_EN
  logic [2:0] sat_idx;
  logic [2:0] sat_top;
  logic       sat_neg;

  always_comb begin
    sum     = raw;
    sat_idx = '0;
    sat_top = '0;
    sat_neg = 1'b0;
    for (int j = 0; j < NumBytes; j++) begin
      sat_idx = 3'(j) >> shift;
      sat_top = 3'(j) | mask;
      sat_neg = a[{sat_top, 3'b111}];
      if (ovf[sat_idx]) begin
        if ((3'(j) & mask) == mask) begin
          sum[8*j +: 8] = sat_neg ? 8'h80 : 8'h7F;
        end else begin
          sum[8*j +: 8] = sat_neg ? 8'h00 : 8'hFF;
        end
      end
    end
  end
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/smul_acc.sv
// Lane-wise accumulator behind smul: sums acc_len+1 packed product beats per result.
// Optional SMUL_ACC_SAT_EN turns lane wrap-around into signed saturation with sticky flags.
module smul_acc
  import smul_acc_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              ce,
  input  logic              sclr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [3:0]        select_precision,
  input  logic [1:0]        enable_fp_unit,
  input  logic [LEN_W-1:0]  acc_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [7:0]        lane_sat
);

  smul_acc_state_t   state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  lane_mode_t        mode_q, mode_d;

  logic [LEN_W-1:0]  cnt_inc;
  logic              beat;
  logic              start;
  logic [DATA_W-1:0] add_sum;
  logic [7:0]        add_ovf;

  smul_acc_lane_add u_lane_add (
    .a    (acc_q),
    .b    (in_data),
    .mode (mode_q),
    .sum  (add_sum),
    .ovf  (add_ovf)
  );

  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      IDLE, ACCUM: in_ready = ce;
      HOLD:        in_ready = ce & out_ready;
      default:     in_ready = 1'b0;
    endcase
  end

  assign beat      = in_valid & in_ready;
  assign cnt_inc   = cnt_q + LEN_W'(1);
  assign out_valid = (state_q == HOLD);
  assign out_data  = acc_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    mode_d  = mode_q;
    start   = 1'b0;

    if (beat) begin
      if (state_q == ACCUM) begin
        acc_d = add_sum;
        cnt_d = cnt_inc;
        if (cnt_inc == len_q) state_d = HOLD;
      end else begin
        // IDLE, or HOLD with the result being taken this cycle.
        start = 1'b1;
      end
    end else if (ce && (state_q == HOLD) && out_ready) begin
      state_d = IDLE;
    end

    if (start) begin
      acc_d   = in_data;
      cnt_d   = '0;
      len_d   = acc_len;
      mode_d  = prec_to_mode(select_precision);
      state_d = ((acc_len == '0) || (enable_fp_unit != 2'd0)) ? HOLD : ACCUM;
    end

    if (sclr) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      mode_q  <= L64;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
    end
  end

`ifdef SMUL_ACC_SAT_EN
  logic [7:0] sat_q, sat_d;

  // Flags accumulate over a result and clear on the next result's first beat.
  always_comb begin
    sat_d = sat_q;
    if (beat && (state_q == ACCUM)) sat_d = sat_q | add_ovf;
    if (start) sat_d = '0;
    if (sclr)  sat_d = '0;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sat_q <= '0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign lane_sat = sat_q;
`else
  logic unused_add_ovf;
  assign unused_add_ovf = ^add_ovf;
  assign lane_sat       = '0;
`endif

endmodule

// File: tb/tb_smul_acc.sv
// Directed, table-driven bench for smul_acc; expectations follow SMUL_ACC_SAT_EN if defined.
module tb_smul_acc;
  import smul_acc_pkg::*;

  logic        clk;
  logic        aresetn;
  logic        ce;
  logic        sclr;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [3:0]  select_precision;
  logic [1:0]  enable_fp_unit;
  logic [7:0]  acc_len;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [7:0]  lane_sat;

  int n_cmp = 0;
  int n_bad = 0;

  smul_acc #(.DATA_W(64), .LEN_W(8)) dut (
    .clk              (clk),
    .aresetn          (aresetn),
    .ce               (ce),
    .sclr             (sclr),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .select_precision (select_precision),
    .enable_fp_unit   (enable_fp_unit),
    .acc_len          (acc_len),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .lane_sat         (lane_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       prec;
    logic [7:0]       len;
    logic [1:0]       fp;
    logic [2:0]       nbeats;
    logic [3:0][63:0] beats;
    logic [63:0]      exp_data;
    logic [7:0]       exp_sat;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] p, input logic [7:0] l, input logic [1:0] f,
                              input logic [2:0] n, input logic [63:0] b0, input logic [63:0] b1,
                              input logic [63:0] b2, input logic [63:0] b3,
                              input logic [63:0] wrap, input logic [63:0] sat,
                              input logic [7:0] flags);
    vec_t v;
    v.prec     = p;
    v.len      = l;
    v.fp       = f;
    v.nbeats   = n;
    v.beats[0] = b0;
    v.beats[1] = b1;
    v.beats[2] = b2;
    v.beats[3] = b3;
`ifdef SMUL_ACC_SAT_EN
    v.exp_data = sat;
    v.exp_sat  = flags;
`else
    v.exp_data = wrap;
    v.exp_sat  = 8'h00;
`endif
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, confirm it is accepted, and clock it in.
  task automatic send(input logic [63:0] d);
    in_valid = 1'b1;
    in_data  = d;
    #1;
    chk("in_ready on beat", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  localparam logic [63:0] Ones8  = 64'h0101_0101_0101_0101;
  localparam logic [63:0] Ones16 = 64'h0001_0001_0001_0001;

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk(PrecInt8, 8'd3, 2'd0, 3'd4, Ones8, Ones8, Ones8, Ones8,
                  64'h0404_0404_0404_0404, 64'h0404_0404_0404_0404, 8'h00);
    vecs[1]  = mk(PrecInt8, 8'd1, 2'd0, 3'd2, 64'h7F7F_7F7F_7F7F_7F7F, Ones8, 64'd0, 64'd0,
                  64'h8080_8080_8080_8080, 64'h7F7F_7F7F_7F7F_7F7F, 8'hFF);
    vecs[2]  = mk(PrecInt64, 8'd1, 2'd0, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 64'd0,
                  64'd1, 64'd1, 8'h00);
    vecs[3]  = mk(PrecInt16, 8'd3, 2'd0, 3'd4, Ones16, Ones16, Ones16, Ones16,
                  64'h0004_0004_0004_0004, 64'h0004_0004_0004_0004, 8'h00);
    vecs[4]  = mk(PrecInt32, 8'd1, 2'd0, 3'd2, 64'h7FFF_FFFF_0000_0001, 64'h0000_0001_FFFF_FFFF,
                  64'd0, 64'd0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_0000_0000, 8'h02);
    vecs[5]  = mk(PrecInt16, 8'd1, 2'd0, 3'd2, 64'h8000_0000_0000_0000, 64'hFFFF_0000_0000_0001,
                  64'd0, 64'd0, 64'h7FFF_0000_0000_0001, 64'h8000_0000_0000_0001, 8'h08);
    vecs[6]  = mk(PrecInt8, 8'd5, 2'd1, 3'd1, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'd0, 64'd0,
                  64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 8'h00);
    vecs[7]  = mk(PrecInt64, 8'd1, 2'd0, 3'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0,
                  64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 8'h01);
    vecs[8]  = mk(4'hF, 8'd1, 2'd0, 3'd2, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'd0, 64'd0,
                  64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 8'h00);
    vecs[9]  = mk(PrecInt8, 8'd0, 2'd0, 3'd1, 64'h0123_4567_89AB_CDEF, 64'd0, 64'd0, 64'd0,
                  64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 8'h00);
    vecs[10] = mk(PrecInt8, 8'd1, 2'd0, 3'd2, 64'h00FF_00FF_00FF_00FF, Ones16, 64'd0, 64'd0,
                  64'd0, 64'd0, 8'h00);

    aresetn          = 1'b0;
    ce               = 1'b1;
    sclr             = 1'b0;
    in_valid         = 1'b0;
    in_data          = '0;
    select_precision = PrecInt8;
    enable_fp_unit   = 2'd0;
    acc_len          = '0;
    out_ready        = 1'b0;

    tick();
    tick();
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_data", out_data, 64'd0);
    chk("reset lane_sat", 64'(lane_sat), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    aresetn = 1'b1;
    tick();

    // Table: after the first beat precision and length are scrambled to prove latching.
    for (int i = 0; i < 11; i++) begin
      select_precision = vecs[i].prec;
      acc_len          = vecs[i].len;
      enable_fp_unit   = vecs[i].fp;
      for (int b = 0; b < int'(vecs[i].nbeats); b++) begin
        send(vecs[i].beats[b]);
        select_precision = PrecInt8;
        acc_len          = 8'd0;
        if (b < int'(vecs[i].nbeats) - 1) begin
          chk($sformatf("v%0d early out_valid", i), 64'(out_valid), 64'd0);
        end
      end
      chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d out_data", i), out_data, vecs[i].exp_data);
      chk($sformatf("v%0d lane_sat", i), 64'(lane_sat), 64'(vecs[i].exp_sat));
      drain();
      chk($sformatf("v%0d out_valid after drain", i), 64'(out_valid), 64'd0);
      enable_fp_unit = 2'd0;
    end

    // Backpressure, then back-to-back results with no bubble.
    select_precision = PrecInt8;
    acc_len          = 8'd0;
    send(64'h1111_1111_1111_1111);
    in_valid = 1'b1;
    in_data  = 64'h2222_2222_2222_2222;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp in_ready", 64'(in_ready), 64'd0);
      chk("bp out_valid", 64'(out_valid), 64'd1);
      chk("bp out_data", out_data, 64'h1111_1111_1111_1111);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("b2b in_ready", 64'(in_ready), 64'd1);
    tick();
    in_data = 64'h3333_3333_3333_3333;
    chk("b2b 1st out_valid", 64'(out_valid), 64'd1);
    chk("b2b 1st out_data", out_data, 64'h2222_2222_2222_2222);
    tick();
    in_valid = 1'b0;
    chk("b2b 2nd out_data", out_data, 64'h3333_3333_3333_3333);
    tick();
    out_ready = 1'b0;
    chk("b2b idle out_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-accumulation, then a clean INT16 run.
    select_precision = PrecInt16;
    acc_len          = 8'd3;
    send(Ones16);
    send(Ones16);
    #2;
    aresetn = 1'b0;
    #1;
    chk("arst out_data", out_data, 64'd0);
    chk("arst out_valid", 64'(out_valid), 64'd0);
    chk("arst lane_sat", 64'(lane_sat), 64'd0);
    tick();
    aresetn = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) send(Ones16);
    chk("post-rst out_valid", 64'(out_valid), 64'd1);
    chk("post-rst out_data", out_data, 64'h0004_0004_0004_0004);
    drain();

    // sclr in HOLD beats a simultaneous handshake and new first beat.
    select_precision = PrecInt8;
    acc_len          = 8'd1;
    send(64'h7F7F_7F7F_7F7F_7F7F);
    send(Ones8);
    chk("pre-sclr out_valid", 64'(out_valid), 64'd1);
    sclr      = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'h5555_5555_5555_5555;
    acc_len   = 8'd0;
    tick();
    sclr      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("sclr out_valid", 64'(out_valid), 64'd0);
    chk("sclr out_data", out_data, 64'd0);
    chk("sclr lane_sat", 64'(lane_sat), 64'd0);

    // ce low mid-ACCUM freezes everything.
    acc_len = 8'd3;
    send(Ones8);
    send(Ones8);
    ce       = 1'b0;
    in_valid = 1'b1;
    in_data  = Ones8;
    #1;
    chk("ce-low in_ready", 64'(in_ready), 64'd0);
    tick();
    tick();
    chk("ce-low out_data", out_data, 64'h0202_0202_0202_0202);
    chk("ce-low out_valid", 64'(out_valid), 64'd0);
    ce       = 1'b1;
    in_valid = 1'b0;
    send(Ones8);
    send(Ones8);
    chk("ce-resume out_valid", 64'(out_valid), 64'd1);
    chk("ce-resume out_data", out_data, 64'h0404_0404_0404_0404);
    drain();

    // Bypass stream: each beat shows up one cycle later, unchanged.
    enable_fp_unit = 2'd1;
    acc_len        = 8'd7;
    out_ready      = 1'b1;
    in_valid       = 1'b1;
    in_data        = 64'hA0A0_0000_1111_0001;
    tick();
    chk("byp 1 out_valid", 64'(out_valid), 64'd1);
    chk("byp 1 out_data", out_data, 64'hA0A0_0000_1111_0001);
    in_data = 64'hB0B0_FFFF_2222_0002;
    tick();
    chk("byp 2 out_data", out_data, 64'hB0B0_FFFF_2222_0002);
    in_data = 64'hC0C0_8000_3333_0003;
    tick();
    chk("byp 3 out_data", out_data, 64'hC0C0_8000_3333_0003);
    in_valid = 1'b0;
    tick();
    chk("byp end out_valid", 64'(out_valid), 64'd0);
    out_ready      = 1'b0;
    enable_fp_unit = 2'd0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/smul_acc.md
# smul_acc

Downstream accumulation stage for the `smul` systolic multiplier. Consumes the packed 64-bit `res_mac_next` products and sums them lane-wise over a programmable number of beats, honouring the SIMD precision split (INT8/16/32/64). Emits one packed accumulated word per dot-product slice over a valid/ready handshake towards the MXU result path.

## Interface
- `DATA_W`, 64: packed product/result width. Fixed at 64.
- `LEN_W`, 8: width of `acc_len`.

- `clk` in 1: sole clock; all state on rising edge.
- `aresetn` in 1: asynchronous, active-low reset.
- `ce` in 1: clock enable; low freezes all state.
- `sclr` in 1: synchronous clear; acts even when `ce` is low.
- `in_valid` in 1: product beat valid.
- `in_ready` out 1: beat accepted when `in_valid & in_ready`.
- `in_data` in 64: packed product from `smul.res_mac_next`.
- `select_precision` in 4: `INT8`/`INT16`/`INT32`/`INT64` codes from `precision_def.vh`; other codes = INT64.
- `enable_fp_unit` in 2: non-zero selects bypass; each beat passes straight to the output.
- `acc_len` in LEN_W: beats per result minus one (0 means 1 beat).
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts.
- `out_data` out 64: packed accumulated result.
- `lane_sat` out 8: per-lane saturation flags, sticky per result. Lane i maps to bit i; INT16 uses bits 0-3.

## Operation
- Three states: IDLE, ACCUM, HOLD.
- **Latching.** `select_precision`, `enable_fp_unit` and `acc_len` are latched on the first beat of each result. Changes during ACCUM/HOLD are ignored.
- **IDLE.**
  - `in_ready` = `ce`.
  - On a beat: `acc<=in_data` and `cnt<=0`.
  - Go to HOLD if the latched `acc_len`==0 or bypass is selected; otherwise go to ACCUM.
- **ACCUM.**
  - `in_ready` = `ce`.
  - On a beat: `acc<=lane_add(acc,in_data)` and `cnt<=cnt+1`.
  - When `cnt+1==acc_len`, go to HOLD.
  - `in_valid` low inserts bubbles with no state change.
- **HOLD.**
  - `out_valid`=1 and `out_data`=`acc`.
  - `in_ready` = `ce & out_ready`.
  - On `out_ready`:
    - A simultaneous input beat starts the next result as in IDLE (next state ACCUM or HOLD).
    - With no simultaneous beat, go to IDLE.
  - `out_data` is stable while `out_valid & !out_ready`.
- **Lane arithmetic.**
  - The lane width is the latched precision. Each lane is a signed two's-complement sum.
  - Carries never cross lane boundaries.
  - Default overflow behaviour is wrap-around modulo 2^lane_width.
- **Bypass mode.** FP products are not accumulated; `acc_len` is ignored.
- **ce low.** Holds state, `acc`, `cnt`, `out_valid` and `out_data`. `in_ready` is 0.
- **sclr.** Forces IDLE, `acc`=0, `cnt`=0, `out_valid`=0, `lane_sat`=0. It has priority over every other event, including a simultaneous handshake.
- **aresetn low.** Same state as `sclr`, applied immediately. A partial accumulation is discarded.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `lane_sat`=0.
  - State IDLE, so `in_ready` follows `ce` after reset.
- `in_ready`/`out_valid` are decoded from registered state. `in_ready` in HOLD depends combinationally on `out_ready`.
- Latency: `out_valid` rises the cycle after the last beat is accepted.
- Throughput: one result per `acc_len+1` beats, with no bubble when `out_ready` is held high.
- The `smul` output lags its inputs by two cycles. The upstream controller aligns `in_valid` accordingly; this block adds no skew.

## Configuration
- `SMUL_ACC_SAT_EN` defined:
  - Lane overflow clamps to the lane's signed max/min, e.g. INT8 to 0x7F/0x80.
  - The lane's `lane_sat` bit sets and holds until the next result's first beat.
  - INT64 saturates to 0x7FFF_FFFF_FFFF_FFFF / 0x8000_0000_0000_0000.
- Not defined: wrap-around arithmetic only; `lane_sat` is tied to 0; the saturation logic is absent.

## Structure
- **Package `smul_acc_pkg`.**
  - State enum `smul_acc_state_t` {IDLE, ACCUM, HOLD}.
  - Lane-mode typedef `lane_mode_t` (L8, L16, L32, L64).
  - Function mapping `select_precision` to `lane_mode_t`.
  - Lane-count constants.
- **Sub-module `smul_acc_lane_add`.**
  - Combinational 64-bit segmented adder.
  - Inputs: `a`, `b`, `lane_mode_t`.
  - Outputs: 64-bit sum and 8-bit overflow vector.
  - Saturation is under `SMUL_ACC_SAT_EN`.
- **Top.** FSM, counter, accumulator register and handshake.

## Test plan
- **INT8 accumulate.** INT8, `acc_len`=3, four beats of 0x0101_0101_0101_0101 → `out_data`=0x0404_0404_0404_0404. `out_valid` is high one cycle after the 4th beat.
- **INT8 overflow.** INT8, `acc_len`=1, beats 0x7F7F_7F7F_7F7F_7F7F then 0x0101_0101_0101_0101:
  - Wrap build: 0x8080_8080_8080_8080.
  - With `SMUL_ACC_SAT_EN`: 0x7F7F_7F7F_7F7F_7F7F and `lane_sat`=0xFF.
- **INT64 and mid-result precision change.** INT64, `acc_len`=1, beats 0xFFFF_FFFF_FFFF_FFFF + 0x2 → 0x1. `select_precision` switched to INT8 after the first beat has no effect.
- **Backpressure and back-to-back.**
  - Hold `out_ready` low 3 cycles in HOLD: `out_data` stable and `in_ready`=0.
  - Then raise `out_ready` with `in_valid` high: the new result's first beat is accepted in the same cycle.
- **Reset and sclr mid-accumulation.**
  - `aresetn` pulsed low after 2 of 4 beats: all outputs 0 immediately; the next 4-beat INT16 run of 0x0001_0001_0001_0001 gives 0x0004_0004_0004_0004.
  - `sclr` in HOLD gives the same clear.
- **ce freeze and bypass.**
  - `ce` low for 2 cycles mid-ACCUM with `in_valid` high: no beats counted and the result is unchanged.
  - `enable_fp_unit`=2'd1: each beat appears on `out_data` unchanged one cycle later.
